// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache fill path: the fill sequencer state
// encoding, block geometry and the arbiter select encoding.
package cache_pkg;

  // 16-bit words per cache block; a block is 2*WORDS bytes.
  localparam int WORDS = 8;

  // Default address width of the memory port.
  localparam int ADDR_W = 16;

  // Clears the byte offset within a 16-byte block.
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  // arbiter_select encoding.
  localparam logic SEL_INSTR = 1'b1;
  localparam logic SEL_DATA  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/fill_word_counter.sv
// fill_word_counter
// Issue and receive counters for one block fill.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero both counters (asserted on entry to a fill)
//   issue_inc   : a memory read was issued this cycle
//   recv_inc    : a memory word came back this cycle
//   issue_cnt   : reads issued so far (0..WORDS, saturates at WORDS)
//   recv_cnt    : words received so far (0..WORDS-1)
//   issue_last  : the read being issued is the final one of the block
//   recv_last   : the word being received is the final one of the block
module fill_word_counter
  import cache_pkg::*;
#(
  parameter int WORDS_P = WORDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       issue_inc,
  input  logic       recv_inc,
  output logic [3:0] issue_cnt,
  output logic [2:0] recv_cnt,
  output logic       issue_last,
  output logic       recv_last
);

  // Both counters restart together at the start of every fill. The issue
  // counter saturates so a stray increment can never wrap it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      issue_cnt <= 4'd0;
      recv_cnt  <= 3'd0;
    end else begin
      if (issue_inc && (issue_cnt != 4'(WORDS_P))) begin
        issue_cnt <= issue_cnt + 4'd1;
      end
      if (recv_inc) begin
        recv_cnt <= recv_cnt + 3'd1;
      end
    end
  end

  assign issue_last = (issue_cnt == 4'(WORDS_P - 1));
  assign recv_last  = (recv_cnt == 3'(WORDS_P - 1));

endmodule

// File: rtl/cache_fill_controller.sv
// cache_fill_controller
// Arbitrates I-cache and D-cache misses onto the single pipelined memory
// port, issues the WORDS word reads of the missing block, steers returning
// words into the granted cache and writes the tag with the final word.
//   clk, rst        : clock, synchronous active-high reset
//   instr_miss/addr : I-cache miss level and byte address
//   data_miss/addr  : D-cache miss level and byte address
//   mem_enable      : registered read issue strobe
//   mem_addr        : registered read address (0 when idle)
//   mem_data_valid  : one pulse per issued read, returned in order
//   arbiter_select  : granted cache, 1 = instr, 0 = data (0 when idle)
//   fill_word_en    : data array write enable for the returning word
//   fill_word_idx   : word index within the block for fill_word_en
//   fill_tag_en     : tag/valid write, coincides with the last word
//   fill_busy       : high while a fill is in progress (FILL and DONE)
//   fill_done       : one-cycle pulse at the end of a fill
module cache_fill_controller
  import cache_pkg::*;
#(
  parameter int WORDS_P = WORDS,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_miss,
  input  logic [ADDR_W_P-1:0] instr_addr,
  input  logic                data_miss,
  input  logic [ADDR_W_P-1:0] data_addr,
  output logic                mem_enable,
  output logic [ADDR_W_P-1:0] mem_addr,
  input  logic                mem_data_valid,
  output logic                arbiter_select,
  output logic                fill_word_en,
  output logic [2:0]          fill_word_idx,
  output logic                fill_tag_en,
  output logic                fill_busy,
  output logic                fill_done
);

  localparam logic [ADDR_W_P-1:0] MASK = ~ADDR_W_P'(2 * WORDS_P - 1);

  fill_state_t         state, next_state;
  logic                grant_q;
  logic [ADDR_W_P-1:0] base_q;
  logic                mem_enable_q;
  logic [ADDR_W_P-1:0] mem_addr_q;

  logic                load;
  logic                load_grant;
  logic [ADDR_W_P-1:0] load_base;
  logic                next_mem_en;
  logic [ADDR_W_P-1:0] next_mem_addr;
  logic [3:0]          next_issue;
  logic                issue_inc;
  logic                recv_inc;

  logic [3:0]          issue_cnt;
  logic [2:0]          recv_cnt;
  logic                issue_last;
  logic                recv_last;

  fill_word_counter #(.WORDS_P(WORDS_P)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (load),
    .issue_inc  (issue_inc),
    .recv_inc   (recv_inc),
    .issue_cnt  (issue_cnt),
    .recv_cnt   (recv_cnt),
    .issue_last (issue_last),
    .recv_last  (recv_last)
  );

  // State, grant/base latch and the registered memory request. The first
  // read is launched on the same edge that enters FILL so that it appears
  // in the first FILL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_q      <= SEL_DATA;
      base_q       <= '0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state        <= next_state;
      mem_enable_q <= next_mem_en;
      mem_addr_q   <= next_mem_addr;
      if (load) begin
        grant_q <= load_grant;
        base_q  <= load_base;
      end
    end
  end

  assign next_issue = issue_cnt + 4'd1;

  // Next-state, arbitration and word steering. Instr has priority; a data
  // miss left waiting is picked up the next time IDLE samples the lines.
  always_comb begin
    next_state    = state;
    load          = 1'b0;
    load_grant    = SEL_DATA;
    load_base     = '0;
    next_mem_en   = 1'b0;
    next_mem_addr = '0;
    issue_inc     = 1'b0;
    recv_inc      = 1'b0;
    fill_word_en  = 1'b0;
    fill_word_idx = 3'd0;
    fill_tag_en   = 1'b0;

    case (state)
      IDLE: begin
        if (instr_miss) begin
          load       = 1'b1;
          load_grant = SEL_INSTR;
          load_base  = instr_addr & MASK;
        end else if (data_miss) begin
          load       = 1'b1;
          load_grant = SEL_DATA;
          load_base  = data_addr & MASK;
        end
        if (load) begin
          next_state    = FILL;
          next_mem_en   = 1'b1;
          next_mem_addr = load_base;
        end
      end

      FILL: begin
        issue_inc = mem_enable_q;
        if (mem_enable_q && !issue_last) begin
          next_mem_en   = 1'b1;
          next_mem_addr = base_q + {{(ADDR_W_P-5){1'b0}}, next_issue, 1'b0};
        end
        if (mem_data_valid) begin
          fill_word_en  = 1'b1;
          fill_word_idx = recv_cnt;
          recv_inc      = 1'b1;
          if (recv_last) begin
            fill_tag_en = 1'b1;
            next_state  = DONE;
          end
        end
      end

      DONE: begin
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign mem_enable     = mem_enable_q;
  assign mem_addr       = mem_addr_q;
  assign arbiter_select = (state != IDLE) ? grant_q : SEL_DATA;
  assign fill_busy      = (state != IDLE);
  assign fill_done      = (state == DONE);

endmodule

// File: doc/cache_fill_controller.md
# cache_fill_controller

Sequential arbiter and fill sequencer between the instruction cache, the data cache and the shared 4-cycle pipelined main memory. On a cache miss it grants memory to one cache, holds that grant for the whole fill, and issues the eight word reads of the 16-byte block. It steers returning words into the granted cache's data array, then writes the tag. It sits between both caches' miss outputs and the single memory port, and replaces purely combinational miss steering with a locked, counted handshake.

## Interface
- WORDS, 8, 16-bit words per cache block (block = 2*WORDS bytes)
- ADDR_W, 16, address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_miss  in  1  I-cache miss request (level, held until fill_done)
- instr_addr  in  ADDR_W  I-cache miss byte address
- data_miss  in  1  D-cache miss request (level, held until fill_done)
- data_addr  in  ADDR_W  D-cache miss byte address
- mem_enable  out  1  memory read issue strobe
- mem_addr  out  ADDR_W  memory read address
- mem_data_valid  in  1  memory read data valid (one per issued read, in order)
- arbiter_select  out  1  granted cache: 1 = instr, 0 = data; held for the whole fill
- fill_word_en  out  1  write-enable to the granted cache's data array
- fill_word_idx  out  3  word index within block for fill_word_en
- fill_tag_en  out  1  tag/valid write-enable to the granted cache
- fill_busy  out  1  high in FILL and DONE
- fill_done  out  1  one-cycle pulse at fill end

## Operation
- States: IDLE, FILL, DONE.
- IDLE: if instr_miss, then next = FILL, grant = 1, base = instr_addr & 16'hFFF0. Else if data_miss, then next = FILL, grant = 0, base = data_addr & 16'hFFF0. Else stay.
- Simultaneous misses: instr wins. The data miss stays pending and is granted in the IDLE cycle after DONE.
- FILL: issue_cnt (4-bit, 0..8) and recv_cnt (3-bit, 0..7) are cleared on entry.
  - While issue_cnt < 8: mem_enable = 1, mem_addr = base + 2*issue_cnt, issue_cnt++.
  - On each mem_data_valid: fill_word_en = 1, fill_word_idx = recv_cnt, recv_cnt++.
  - When mem_data_valid arrives with recv_cnt == 7: fill_tag_en = 1 in the same cycle, next = DONE.
- DONE: fill_done = 1 for one cycle, next = IDLE. The miss input is re-sampled in IDLE, never in DONE.
- Address arithmetic is mod 2^ADDR_W. The base is block-aligned, so no carry out of bits [3:0]. Base 16'hFFF0 gives last address 16'hFFFE.
- Miss address or miss level changes during FILL/DONE are ignored. Base and grant are latched.
- mem_data_valid in IDLE or DONE is ignored, covering stale responses after reset.
- The controller does not depend on memory latency; it counts valids.

## Timing
- Reset values: state = IDLE, counters = 0, base = 0, grant = 0. All outputs are 0: mem_enable, mem_addr = 16'h0000, arbiter_select, fill_word_en, fill_word_idx, fill_tag_en, fill_busy, fill_done.
- Outputs in IDLE: mem_addr = 0, arbiter_select = 0. No high-Z is driven.
- The miss is seen at edge E0. FILL cycles 1..8 (after E0) issue reads; mem_addr is registered.
- With a 4-cycle memory, valids arrive in FILL cycles 5..12. fill_word_en and fill_tag_en are combinational from mem_data_valid and state.
- DONE is FILL cycle 13. Total occupancy is 13 busy cycles per fill.
- Back-to-back: the earliest next FILL entry is 2 edges after DONE (DONE, then IDLE sampling).
- rst high in any cycle: IDLE on the next edge, any fill is abandoned, and no fill_tag_en is ever produced for a partial block.

## Structure
- Shared package (cache_pkg): fill state enum {IDLE, FILL, DONE}, WORDS, BLOCK_MASK = 16'hFFF0, SEL_INSTR = 1'b1 and SEL_DATA = 1'b0.
- One natural sub-module: fill_word_counter (issue/receive counters with terminal flags), instantiated once.
- FSM, grant latch and address generator stay in the top.

## Test plan
- instr_miss=1, instr_addr=16'h1234, 4-cycle memory -> mem_addr sequence 0x1230..0x123E over 8 cycles, arbiter_select=1 throughout. fill_word_idx runs 0..7, fill_tag_en is high with idx 7, then fill_done is pulsed once.
- instr_miss and data_miss both high (data_addr=16'h8006) -> instr fill completes first. The data fill then issues 0x8000..0x800E with arbiter_select=0 and no cycle overlaps.
- data_addr=16'hFFFA -> addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
- rst pulsed after the 3rd fill_word_en -> all outputs 0 next cycle. Late mem_data_valid pulses produce no fill_word_en, and no fill_tag_en occurs.
- mem_data_valid with gaps (memory latency jittered 4..7 cycles) -> exactly 8 word writes in order, and fill_done follows the 8th valid.
- instr_addr changed mid-fill -> addresses remain those of the latched block.
